mixcolumn_serial: RTL and testbench

Column-serial forward AES MixColumns engine for the encrypt datapath. It accepts one 128-bit state through a valid/ready handshake and processes one 32-bit column per clock. It presents the mixed state on a held output handshake. A per-block bypass flag passes the state through unchanged with identical latency, for the final round where MixColumns is skipped.

---
 rtl/mixcolumn_serial.sv | 131 +++++++++++++
 tb/tb_mixcolumn_serial.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumn_serial.sv
// mixcolumn_serial: column-serial forward AES MixColumns engine.
// Accepts a 128-bit state on a valid/ready handshake, mixes one 32-bit column
// per clock, then holds the result until the downstream side takes it.
// A per-block bypass flag passes the state through unchanged.
// The latency is the same with or without bypass, for the final round.
//
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   valid_i / ready_o  - input handshake (ready_o is combinational on ready_i)
//   data_i, bypass_i   - input state and per-block bypass flag
//   valid_o / ready_i  - output handshake, valid_o held until taken
//   data_o             - mixed (or bypassed) state
module mixcolumn_serial (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic         bypass_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [STATE_W-1:0] in_q;
    logic [STATE_W-1:0] res_q;
    logic               byp_q;
    logic [1:0]         cnt;

    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;
    logic               accept;

    // Multiply by 2 in GF(2^8), reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on a single column; byte 0 in bits [7:0]
    function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] c);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] o0, o1, o2, o3;
        s0 = c[7:0];
        s1 = c[15:8];
        s2 = c[23:16];
        s3 = c[31:24];
        o0 = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
        o1 = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
        o2 = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
        o3 = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
        return {o3, o2, o1, o0};
    endfunction

    // Output side frees the slot in the same cycle it is taken
    assign ready_o = (state == IDLE) | ((state == DONE) & ready_i);
    assign accept  = valid_i & ready_o;
    assign data_o  = res_q;

    // Select the column being processed this cycle
    always_comb begin
        col_in = in_q[31:0];
        case (cnt)
            2'd0: col_in = in_q[31:0];
            2'd1: col_in = in_q[63:32];
            2'd2: col_in = in_q[95:64];
            2'd3: col_in = in_q[127:96];
            default: col_in = in_q[31:0];
        endcase
        col_out = byp_q ? col_in : mix_col(col_in);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            in_q    <= '0;
            res_q   <= '0;
            byp_q   <= 1'b0;
            cnt     <= 2'd0;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_q  <= data_i;
                        byp_q <= bypass_i;
                        cnt   <= 2'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res_q[{cnt, 5'b0} +: COL_W] <= col_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        // Take the outgoing block and admit the next on one edge
                        if (valid_i) begin
                            in_q  <= data_i;
                            byp_q <= bypass_i;
                            cnt   <= 2'd0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumn_serial.sv
// tb_mixcolumn_serial: self-checking bench for mixcolumn_serial.
// Directed steps plus a randomized stream; expected blocks are queued on
// accept and compared when the output handshake completes.
module tb_mixcolumn_serial;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [127:0] data_i = '0;
    logic         bypass_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [127:0] data_o;

    int n_vec = 0;
    int n_err = 0;
    int n_sent = 0;
    int n_rcv = 0;
    int cyc = 0;
    int last_out = -100;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KNOWN_IN  = {32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db};
    localparam logic [127:0] KNOWN_OUT = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};

    mixcolumn_serial dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .bypass_i(bypass_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Golden model: generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? (8'({aa[6:0], 1'b0}) ^ 8'h1b) : 8'({aa[6:0], 1'b0});
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic byp);
        logic [127:0] r;
        logic [7:0] s [4];
        logic [7:0] m [4][4];
        m[0] = '{8'h02, 8'h03, 8'h01, 8'h01};
        m[1] = '{8'h01, 8'h02, 8'h03, 8'h01};
        m[2] = '{8'h01, 8'h01, 8'h02, 8'h03};
        m[3] = '{8'h03, 8'h01, 8'h01, 8'h02};
        r = d;
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) s[j] = d[32*c + 8*j +: 8];
                for (int row = 0; row < 4; row++) begin
                    r[32*c + 8*row +: 8] = gmul(m[row][0], s[0]) ^ gmul(m[row][1], s[1])
                                         ^ gmul(m[row][2], s[2]) ^ gmul(m[row][3], s[3]);
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                n_vec++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected: observed %h expected none", data_o);
                end
                if (exp_q.size() > 0) begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    n_vec++;
                    assert (data_o === e) else begin
                        n_err++;
                        $error("FAIL sb_data: observed %h expected %h", data_o, e);
                    end
                end
                n_vec++;
                assert (cyc - last_out >= 5) else begin
                    n_err++;
                    $error("FAIL period: observed %0d expected >=5", cyc - last_out);
                end
                last_out = cyc;
                n_rcv++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(model(data_i, bypass_i));
                n_sent++;
            end
        end
    end

    // Drive a block and return 1 time unit after its accept edge
    task automatic send(input logic [127:0] d, input logic byp);
        int guard = 0;
        data_i   = d;
        bypass_i = byp;
        valid_i  = 1'b1;
        forever begin
            @(negedge clk_i);
            if (ready_o || guard > 100) break;
            guard++;
        end
        if (guard > 100) check("send_timeout", 128'(ready_o), 128'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        data_i  = $urandom();
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!valid_o && guard < 100) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (guard >= 100) check("valid_timeout", 128'(valid_o), 128'd1);
    endtask

    task automatic take();
        wait_valid();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("taken_valid_low", 128'(valid_o), 128'd0);
    endtask

    task automatic latency_check(input string tag);
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        check({tag, "_lat_e3"}, 128'(valid_o), 128'd0);
        @(posedge clk_i); #1;
        check({tag, "_lat_e4"}, 128'(valid_o), 128'd1);
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] v;
        logic [127:0] fixed_pts [3];
        int guard;

        // Reset
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 128'(valid_o), 128'd0);
        check("rst_ready", 128'(ready_o), 128'd1);
        check("rst_data", data_o, 128'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Known vector with exact latency
        send(KNOWN_IN, 1'b0);
        latency_check("known");
        check("known_data", data_o, KNOWN_OUT);
        take();

        // Fixed points
        fixed_pts[0] = {16{8'h01}};
        fixed_pts[1] = {16{8'hc6}};
        fixed_pts[2] = '0;
        for (int i = 0; i < 3; i++) begin
            send(fixed_pts[i], 1'b0);
            wait_valid();
            check("fixed_point", data_o, fixed_pts[i]);
            take();
        end

        // Bypass, then the flag must not stick to the next block
        send(KNOWN_IN, 1'b1);
        latency_check("bypass");
        check("bypass_data", data_o, KNOWN_IN);
        take();
        send(KNOWN_IN, 1'b0);
        wait_valid();
        check("after_bypass", data_o, KNOWN_OUT);
        take();

        // Backpressure for 10 cycles with an ignored valid_i pulse
        send({32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10}, 1'b0);
        wait_valid();
        held = data_o;
        check("bp_held_model", held, model({32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10}, 1'b0));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                valid_i = 1'b1;
                data_i  = {4{32'hdeadbeef}};
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            check("bp_ready", 128'(ready_o), 128'd0);
            @(posedge clk_i); #1;
            check("bp_data", data_o, held);
            check("bp_valid", 128'(valid_o), 128'd1);
        end
        v = {32'hcafef00d, 32'h12345678, 32'h9abcdef0, 32'h0badc0de};
        valid_i  = 1'b1;
        data_i   = v;
        bypass_i = 1'b0;
        ready_i  = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("bp_overlap_busy", 128'(ready_o), 128'd0);
        wait_valid();
        check("bp_overlap_data", data_o, model(v, 1'b0));
        take();

        // Reset during the second BUSY edge
        send({4{32'h11223344}}, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        check("mid_rst_valid", 128'(valid_o), 128'd0);
        check("mid_rst_ready", 128'(ready_o), 128'd1);
        check("mid_rst_data", data_o, 128'd0);
        ready_i = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        check("mid_rst_no_emit", 128'(valid_o), 128'd0);
        ready_i = 1'b0;
        send(KNOWN_IN, 1'b0);
        wait_valid();
        check("post_rst_data", data_o, KNOWN_OUT);
        take();

        // Random streaming with gaps and backpressure
        n_sent = 0;
        n_rcv  = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_i); #1;
                    end
                    send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
                end
            end
            begin
                guard = 0;
                while (n_rcv < 1000 && guard < 40000) begin
                    @(posedge clk_i); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                    guard++;
                end
                ready_i = 1'b0;
            end
        join
        check("stream_count", 128'(n_rcv), 128'd1000);
        check("stream_sent", 128'(n_sent), 128'd1000);
        check("stream_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
